piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake and drives it LSB-first onto a one-bit serial line, one bit per clock. It is the stage directly upstream of the team's 4-bit serial-in/parallel-out register and feeds that register's `d_in`. Because bits are sent LSB-first, a downstream 4-bit SIPO clocked on the same edge holds the complete word, in original bit order, during the cycle that `word_done` is high.

---
 rtl/serdes_pkg.sv | 18 +
 rtl/piso_serializer_tx_bit_counter.sv | 48 ++++
 rtl/piso_serializer.sv | 185 ++++++++++++++++++
 tb/tb_piso_serializer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// ---------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the serial link stages (PISO transmitter and the
// matching SIPO receiver): frame state encoding and the default word width.
// ---------------------------------------------------------------------------
package serdes_pkg;

  // Default data word width of the serial link
  localparam int SERDES_WIDTH = 4;

  // Frame state encoding; ST_PAR is only reachable when parity is built in
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } serdes_state_t;

endpackage

// File: rtl/piso_serializer_tx_bit_counter.sv
// ---------------------------------------------------------------------------
// tx_bit_counter
// Modulo-WIDTH bit counter for the PISO transmitter. Counts 0..WIDTH-1 and
// flags the terminal count so the FSM knows the last data bit is on the line.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (counter -> 0)
//   i_clr  in   synchronous clear (has priority over i_en)
//   i_en   in   advance by one
//   o_tc   out  high while the count equals WIDTH-1
// ---------------------------------------------------------------------------
module tx_bit_counter
  import serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Bit count register: clear on a new word, advance once per shifted bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_tc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out transmitter. A WIDTH-bit word is taken over a
// valid/ready handshake and sent LSB-first on d_out, one bit per clock, so a
// downstream LSB-first SIPO on the same clock holds the word while word_done
// is high. Back-to-back words are sent without an idle gap.
//
// Build option:
//   PISO_PARITY_EN  appends one even-parity bit (XOR of the word) per frame
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_data    in   [WIDTH] parallel word, sampled only on the handshake edge
//   in_valid   in   in_data is valid
//   in_ready   out  combinational; accept when in_valid && in_ready
//   d_out      out  registered serial data, 0 when idle
//   busy       out  registered; high while d_out carries a frame bit
//   word_done  out  registered one-cycle end-of-word pulse
// ---------------------------------------------------------------------------
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = SERDES_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_out,
  output logic             busy,
  output logic             word_done
);

  serdes_state_t    r_state;
  serdes_state_t    w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             r_dout;
  logic             r_busy;
  logic             r_done;
  logic             w_dout_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_in_ready;
  logic             w_hs;
  logic             w_tc;

`ifdef PISO_PARITY_EN
  logic r_par;

  // Even parity: data plus this bit carries an even number of ones
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction
`endif

  tx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_hs),
    .i_en  (r_state == ST_SHIFT),
    .o_tc  (w_tc)
  );

  // Ready: idle, or the slot where the next word can follow with no gap
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
`ifdef PISO_PARITY_EN
      ST_SHIFT: w_in_ready = 1'b0;
      ST_PAR:   w_in_ready = 1'b1;
`else
      ST_SHIFT: w_in_ready = w_tc;
`endif
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_hs = in_valid && w_in_ready;

  // Frame state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) w_state_nxt = ST_SHIFT;
        else      w_state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        if (w_tc) begin
`ifdef PISO_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          if (w_hs) w_state_nxt = ST_SHIFT;
          else      w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        if (w_hs) w_state_nxt = ST_SHIFT;
        else      w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and next output values; outputs follow the state being entered
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_hs) begin
      w_shift_nxt = in_data;
    end else if (r_state == ST_SHIFT) begin
      w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
    end else begin
      w_shift_nxt = r_shift;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    // Last data bit is on the line now; the pulse lands in the next cycle
    w_done_nxt = (r_state == ST_SHIFT) && w_tc;

    w_dout_nxt = 1'b0;
    if (w_state_nxt == ST_SHIFT) begin
      w_dout_nxt = w_shift_nxt[0];
`ifdef PISO_PARITY_EN
    end else if (w_state_nxt == ST_PAR) begin
      w_dout_nxt = r_par;
`endif
    end else begin
      w_dout_nxt = 1'b0;
    end
  end

  // Shift register (and parity of the captured word)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_shift <= w_shift_nxt;
`ifdef PISO_PARITY_EN
      if (w_hs) r_par <= even_parity(in_data);
`endif
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_dout <= w_dout_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign d_out     = r_dout;
  assign busy      = r_busy;
  assign word_done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer (WIDTH = 4). The DUT output feeds a
// 4-bit LSB-first SIPO model; all expected values are hand-derived.
// Honours PISO_PARITY_EN (frame grows to 5 bits, parity scenarios added).
// ---------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       d_out;
  logic       busy;
  logic       word_done;
  logic [3:0] sipo = 4'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Downstream 4-bit LSB-first SIPO fed by d_out
  always @(posedge clk) sipo <= {d_out, sipo[3:1]};

  piso_serializer #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_out     (d_out),
    .busy      (busy),
    .word_done (word_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    #1;
    repeat (3) begin
      tick();
      checks++;
      if ({in_ready, d_out, busy, word_done} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state: ready/d/busy/done got %b expected 1000",
                 {in_ready, d_out, busy, word_done});
      end
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    checks++;
    if ({d_out, busy, word_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_capture: d/busy/done got %b expected 000",
               {d_out, busy, word_done});
    end
  endtask

  task automatic test_single();
    logic [3:0] w;
    logic [2:0] exp;
    w = 4'b1011;
    in_data  = w;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({d_out, busy, word_done} !== {w[k], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL single_bit%0d: d/busy/done got %b expected %b",
                 k, {d_out, busy, word_done}, {w[k], 1'b1, 1'b0});
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    exp = 3'b111;
`else
    exp = 3'b001;
`endif
    checks++;
    if ({d_out, busy, word_done} !== exp) begin
      errors++;
      $display("FAIL single_end: d/busy/done got %b expected %b",
               {d_out, busy, word_done}, exp);
    end
    checks++;
    if (sipo !== 4'hB) begin
      errors++;
      $display("FAIL single_sipo: got %h expected b", sipo);
    end
    tick();
    checks++;
    if ({d_out, busy, word_done} !== 3'b000) begin
      errors++;
      $display("FAIL single_after: d/busy/done got %b expected 000",
               {d_out, busy, word_done});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    logic [2:0] exp;
    logic       ed;
    int         idx;
    in_data  = 4'hA;
    in_valid = 1'b1;
    tick();
    in_data = 4'h5;
    for (int c = 1; c <= 2 * FRAME + 1; c++) begin
      w   = (c <= FRAME) ? 4'hA : 4'h5;
      idx = (c - 1) % FRAME;
      // both 4'hA and 4'h5 have even weight, so their parity bit is 0
      ed  = (c > 2 * FRAME) ? 1'b0 : ((idx < 4) ? w[idx] : 1'b0);
      exp = {ed, (c <= 2 * FRAME), (c == 5 || c == FRAME + 5)};
      checks++;
      if ({d_out, busy, word_done} !== exp) begin
        errors++;
        $display("FAIL b2b cycle %0d: d/busy/done got %b expected %b",
                 c, {d_out, busy, word_done}, exp);
      end
      if (c == 5 || c == FRAME + 5) begin
        checks++;
        if (sipo !== ((c == 5) ? 4'hA : 4'h5)) begin
          errors++;
          $display("FAIL b2b_sipo cycle %0d: got %h expected %h",
                   c, sipo, (c == 5) ? 4'hA : 4'h5);
        end
      end
      if (c == FRAME + 1) in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_hold_busy();
    logic [3:0] w;
    logic [3:0] exp;
    logic       ed;
    int         idx;
    in_data  = 4'b1011;
    in_valid = 1'b1;
    tick();
    for (int c = 1; c <= 2 * FRAME + 1; c++) begin
      if (c == 2) in_data = 4'hF;
      w   = (c <= FRAME) ? 4'b1011 : 4'hF;
      idx = (c - 1) % FRAME;
      // parity of 4'b1011 is 1, of 4'hF is 0
      ed  = (c > 2 * FRAME) ? 1'b0 :
            ((idx < 4) ? w[idx] : (c <= FRAME));
      exp = {ed, (c <= 2 * FRAME), (c == 5 || c == FRAME + 5),
             (c == FRAME || c >= 2 * FRAME)};
      checks++;
      if ({d_out, busy, word_done, in_ready} !== exp) begin
        errors++;
        $display("FAIL hold cycle %0d: d/busy/done/ready got %b expected %b",
                 c, {d_out, busy, word_done, in_ready}, exp);
      end
      if (c == 5 || c == FRAME + 5) begin
        checks++;
        if (sipo !== ((c == 5) ? 4'hB : 4'hF)) begin
          errors++;
          $display("FAIL hold_sipo cycle %0d: got %h expected %h",
                   c, sipo, (c == 5) ? 4'hB : 4'hF);
        end
      end
      if (c == FRAME + 1) in_valid = 1'b0;
      tick();
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity(input logic [3:0] w, input logic par);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({in_ready, d_out} !== {1'b0, w[3]}) begin
      errors++;
      $display("FAIL parity_lastbit %h: ready/d got %b expected %b",
               w, {in_ready, d_out}, {1'b0, w[3]});
    end
    tick();
    checks++;
    if ({d_out, busy, word_done, in_ready} !== {par, 3'b111}) begin
      errors++;
      $display("FAIL parity_bit %h: d/busy/done/ready got %b expected %b",
               w, {d_out, busy, word_done, in_ready}, {par, 3'b111});
    end
    tick();
  endtask
`endif

  task automatic test_reset_midframe();
    logic [3:0] w;
    logic [2:0] exp;
    in_data  = 4'hF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({d_out, busy} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_pre: d/busy got %b expected 11", {d_out, busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, d_out, busy, word_done} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_async: ready/d/busy/done got %b expected 1000",
               {in_ready, d_out, busy, word_done});
    end
    tick();
    reset    = 1'b0;
    w        = 4'h6;
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= FRAME + 1; c++) begin
      // parity of 4'h6 is 0
      exp = {((c <= 4) ? w[(c - 1) % 4] : 1'b0), (c <= FRAME), (c == 5)};
      checks++;
      if ({d_out, busy, word_done} !== exp) begin
        errors++;
        $display("FAIL midreset_next cycle %0d: d/busy/done got %b expected %b",
                 c, {d_out, busy, word_done}, exp);
      end
      if (c == 5) begin
        checks++;
        if (sipo !== 4'h6) begin
          errors++;
          $display("FAIL midreset_sipo: got %h expected 6", sipo);
        end
      end
      tick();
    end
  endtask

  task automatic test_idle();
    in_valid = 1'b0;
    repeat (20) begin
      tick();
      checks++;
      if ({d_out, busy, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL idle: d/busy/ready got %b expected 001",
                 {d_out, busy, in_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_busy();
`ifdef PISO_PARITY_EN
    test_parity(4'b0111, 1'b1);
    test_parity(4'b0011, 1'b0);
`endif
    test_reset_midframe();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
